// File: rtl/vga_rx_monitor.sv
// VGA receive-side monitor: recovers pixel coordinates, lock state and timing errors
// from hsync/vsync/rgb, and captures one selected pixel. Optional VGA_RX_CHECKSUM_EN adds frame_sum.
module vga_rx_monitor #(
    parameter int H_OFFSET  = 144,
    parameter int V_OFFSET  = 34,
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int H_TOTAL   = 800,
    parameter int V_TOTAL   = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [7:0]  rgb,
    input  logic [9:0]  cap_x,
    input  logic [9:0]  cap_y,
    input  logic        cap_arm,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [7:0]  pix_data,
    output logic        frame_start,
    output logic [7:0]  cap_data,
    output logic        cap_done,
    output logic        err,
`ifdef VGA_RX_CHECKSUM_EN
    output logic [15:0] frame_sum,
`endif
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {SEEK, TRAIN, LOCKED} state_t;

    localparam logic [9:0]  H_START   = 10'(H_OFFSET);
    localparam logic [9:0]  H_END     = 10'(H_OFFSET + H_DISPLAY);
    localparam logic [9:0]  V_START   = 10'(V_OFFSET);
    localparam logic [9:0]  V_END     = 10'(V_OFFSET + V_DISPLAY);
    localparam logic [10:0] LINE_GOOD = 11'(H_TOTAL);
    localparam logic [10:0] FRAME_GOOD = 11'(V_TOTAL);
    localparam logic [9:0]  CNT_MAX   = 10'h3FF;

    state_t      state_reg;
    logic [1:0]  good_reg;
    logic        frame_clean_reg;
    logic        hs_prev_reg, vs_prev_reg, vs_pend_reg;
    logic [9:0]  h_cnt_reg, v_cnt_reg;
    logic        locked_reg, pix_valid_reg, frame_start_reg, err_reg;
    logic [9:0]  x_reg, y_reg;
    logic [7:0]  pix_data_reg, err_cnt_reg;
    logic [9:0]  cap_x_reg, cap_y_reg;
    logic        armed_reg, cap_done_reg;
    logic [7:0]  cap_data_reg;

    logic        hs_fall, vs_fall, frame_edge;
    logic [9:0]  h_cnt_next, v_cnt_next, x_next, y_next;
    logic [10:0] line_len, frame_len;
    logic        line_ok, frame_ok, violation, active, pix_fire;

    always_comb begin
        hs_fall    = p_tick && hs_prev_reg && !hsync;
        vs_fall    = p_tick && vs_prev_reg && !vsync;
        frame_edge = hs_fall && vs_pend_reg;
        line_len   = {1'b0, h_cnt_reg} + 11'd1;
        frame_len  = {1'b0, v_cnt_reg} + 11'd1;
        line_ok    = (line_len == LINE_GOOD);
        frame_ok   = (frame_len == FRAME_GOOD);

        h_cnt_next = h_cnt_reg;
        if (hs_fall)
            h_cnt_next = '0;
        else if (p_tick && h_cnt_reg != CNT_MAX)
            h_cnt_next = h_cnt_reg + 10'd1;

        v_cnt_next = v_cnt_reg;
        if (frame_edge)
            v_cnt_next = '0;
        else if (hs_fall && v_cnt_reg != CNT_MAX)
            v_cnt_next = v_cnt_reg + 10'd1;

        // Coordinates belong to the tick being sampled, i.e. the updated counters.
        x_next    = h_cnt_next - H_START;
        y_next    = v_cnt_next - V_START;
        violation = (state_reg == LOCKED) && hs_fall && (!line_ok || (frame_edge && !frame_ok));
        active    = p_tick && (h_cnt_next >= H_START) && (h_cnt_next < H_END) &&
                    (v_cnt_next >= V_START) && (v_cnt_next < V_END);
        pix_fire  = active && locked_reg && !violation;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_prev_reg     <= 1'b0;
            vs_prev_reg     <= 1'b0;
            vs_pend_reg     <= 1'b0;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            pix_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            pix_data_reg    <= '0;
        end else begin
            if (p_tick) begin
                hs_prev_reg <= hsync;
                vs_prev_reg <= vsync;
            end
            if (frame_edge)
                vs_pend_reg <= 1'b0;
            if (vs_fall)
                vs_pend_reg <= 1'b1;
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            pix_valid_reg   <= pix_fire;
            frame_start_reg <= pix_fire && (x_next == 10'd0) && (y_next == 10'd0);
            if (pix_fire) begin
                x_reg        <= x_next;
                y_reg        <= y_next;
                pix_data_reg <= rgb;
            end
        end
    end

    // Lock FSM. frame_clean starts low on entry to TRAIN: the frame in flight
    // (and its first line) began before we were watching, so it never counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= SEEK;
            good_reg        <= '0;
            frame_clean_reg <= 1'b0;
            locked_reg      <= 1'b0;
            err_reg         <= 1'b0;
            err_cnt_reg     <= '0;
        end else begin
            err_reg <= violation;
            case (state_reg)
                SEEK: begin
                    if (vs_fall) begin
                        state_reg       <= TRAIN;
                        good_reg        <= '0;
                        frame_clean_reg <= 1'b0;
                    end
                end
                TRAIN: begin
                    if (frame_edge) begin
                        if (frame_clean_reg && line_ok && frame_ok) begin
                            good_reg <= good_reg + 2'd1;
                            if (good_reg == 2'd1) begin
                                state_reg  <= LOCKED;
                                locked_reg <= 1'b1;
                            end
                        end else begin
                            good_reg <= '0;
                        end
                        frame_clean_reg <= 1'b1;
                    end else if (hs_fall && !line_ok) begin
                        frame_clean_reg <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (violation) begin
                        state_reg  <= SEEK;
                        locked_reg <= 1'b0;
                        if (err_cnt_reg != 8'hFF)
                            err_cnt_reg <= err_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg  <= SEEK;
                    locked_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_x_reg    <= '0;
            cap_y_reg    <= '0;
            armed_reg    <= 1'b0;
            cap_done_reg <= 1'b0;
            cap_data_reg <= '0;
        end else if (p_tick && cap_arm) begin
            cap_x_reg    <= cap_x;
            cap_y_reg    <= cap_y;
            armed_reg    <= 1'b1;
            cap_done_reg <= 1'b0;
        end else if (armed_reg && pix_fire && x_next == cap_x_reg && y_next == cap_y_reg) begin
            cap_data_reg <= rgb;
            cap_done_reg <= 1'b1;
            armed_reg    <= 1'b0;
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc_reg, frame_sum_reg;
    logic [15:0] acc_in;

    always_comb begin
        acc_in = pix_valid_reg ? {8'd0, pix_data_reg} : 16'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg       <= '0;
            frame_sum_reg <= '0;
        end else if (violation) begin
            acc_reg <= '0;
        end else if (frame_edge) begin
            if (locked_reg)
                frame_sum_reg <= acc_reg + acc_in;
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_reg + acc_in;
        end
    end

    assign frame_sum = frame_sum_reg;
`endif

    assign locked      = locked_reg;
    assign pix_valid   = pix_valid_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign pix_data    = pix_data_reg;
    assign frame_start = frame_start_reg;
    assign cap_data    = cap_data_reg;
    assign cap_done    = cap_done_reg;
    assign err         = err_reg;
    assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Table-driven bench for vga_rx_monitor on a shrunken 16x8 timing (8x4 active, offsets 4/2).
// Build with VGA_RX_CHECKSUM_EN defined to also check frame_sum.
module tb_vga_rx_monitor;

    localparam int HO = 4, VO = 2, HD = 8, VD = 4, HT = 16, VT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p_tick = 1'b0, hsync = 1'b1, vsync = 1'b1, cap_arm = 1'b0;
    logic [7:0] rgb = '0;
    logic [9:0] cap_x = '0, cap_y = '0;
    logic       locked, pix_valid, frame_start, cap_done, err;
    logic [9:0] x, y;
    logic [7:0] pix_data, cap_data, err_cnt;
`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    vga_rx_monitor #(
        .H_OFFSET(HO), .V_OFFSET(VO), .H_DISPLAY(HD),
        .V_DISPLAY(VD), .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .cap_x(cap_x), .cap_y(cap_y), .cap_arm(cap_arm),
        .locked(locked), .pix_valid(pix_valid), .x(x), .y(y), .pix_data(pix_data),
        .frame_start(frame_start), .cap_data(cap_data), .cap_done(cap_done),
        .err(err),
`ifdef VGA_RX_CHECKSUM_EN
        .frame_sum(frame_sum),
`endif
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int hc = 0, lc = 0, mode = 0, stretch_line = -1;
    bit arm_req = 1'b0;
    int pv_cnt, fs_cnt, bad_cnt, errp_cnt;

    typedef struct {
        int mode; int stretch; int frames; int exp_locked;
        int exp_pix; int exp_fs; int exp_errp; int exp_err_cnt;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_rgb(input int m, input int xx, input int yy);
        bit act;
        act = (xx >= 0) && (xx < HD) && (yy >= 0) && (yy < VD);
        case (m)
            0: return 8'hA5;
            1: return act ? 8'(xx + 16 * yy) : 8'hFF;
            2: return (xx == 5 && yy == 2) ? 8'h3C : 8'h00;
            default: return 8'h01;
        endcase
    endfunction

    // One p_tick: drive sync/rgb for (hc,lc), then sample the registered outputs.
    task automatic do_tick();
        int len, xx, yy;
        logic [7:0] exp_rgb;
        len = (lc == stretch_line) ? HT + 1 : HT;
        xx = hc - HO;
        yy = lc - VO;
        exp_rgb = model_rgb(mode, xx, yy);
        @(negedge clk);
        hsync   = (hc >= 2);
        vsync   = !((lc == VT - 1 && hc >= 8) || lc == 0);
        rgb     = exp_rgb;
        cap_arm = arm_req;
        p_tick  = 1'b1;
        @(negedge clk);
        p_tick  = 1'b0;
        cap_arm = 1'b0;
        arm_req = 1'b0;
        if (pix_valid) begin
            pv_cnt++;
            if (xx < 0 || xx >= HD || yy < 0 || yy >= VD ||
                int'(x) != xx || int'(y) != yy || pix_data != exp_rgb)
                bad_cnt++;
        end
        if (frame_start) begin
            fs_cnt++;
            if (!(pix_valid && x == 10'd0 && y == 10'd0))
                bad_cnt++;
        end
        if (err)
            errp_cnt++;
        hc++;
        if (hc >= len) begin
            hc = 0;
            lc = (lc + 1) % VT;
        end
    endtask

    task automatic run_frames(input int n);
        pv_cnt = 0; fs_cnt = 0; bad_cnt = 0; errp_cnt = 0;
        for (int f = 0; f < n; f++) begin
            do_tick();
            while (!(hc == 0 && lc == 0))
                do_tick();
        end
    endtask

    initial begin
        //          mode stretch frames locked pix fs errp errcnt
        vecs[0] = '{0, -1, 3, 0,  0, 0, 0, 0};   // training: lock lands on the 3rd vsync boundary
        vecs[1] = '{0, -1, 1, 1, 32, 1, 0, 0};   // first locked frame, constant A5
        vecs[2] = '{1, -1, 1, 1, 32, 1, 0, 0};   // coordinate pattern
        vecs[3] = '{0,  3, 1, 0, 16, 1, 1, 1};   // one 17-tick line breaks lock
        vecs[4] = '{0, -1, 2, 0,  0, 0, 0, 1};   // retraining
        vecs[5] = '{1, -1, 1, 1, 32, 1, 0, 1};   // relocked

        repeat (3) @(negedge clk);
        check("reset_outputs", int'(|{locked, pix_valid, x, y, pix_data, frame_start,
                                      cap_data, cap_done, err, err_cnt}), 0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].mode;
            stretch_line = vecs[i].stretch;
            run_frames(vecs[i].frames);
            stretch_line = -1;
            check($sformatf("vec%0d_locked", i), int'(locked), vecs[i].exp_locked);
            check($sformatf("vec%0d_pix_count", i), pv_cnt, vecs[i].exp_pix);
            check($sformatf("vec%0d_frame_start", i), fs_cnt, vecs[i].exp_fs);
            check($sformatf("vec%0d_err_pulses", i), errp_cnt, vecs[i].exp_errp);
            check($sformatf("vec%0d_err_cnt", i), int'(err_cnt), vecs[i].exp_err_cnt);
            check($sformatf("vec%0d_bad_pixels", i), bad_cnt, 0);
        end

        // Capture at (5,2); live coordinates change after arming.
        mode = 2; cap_x = 10'd5; cap_y = 10'd2; arm_req = 1'b1;
        do_tick();
        cap_x = 10'd1; cap_y = 10'd1;
        run_frames(1);
        check("cap1_done", int'(cap_done), 1);
        check("cap1_data", int'(cap_data), 8'h3C);

        // Off-screen target: arming clears done, nothing ever matches.
        cap_x = 10'd12; cap_y = 10'd0; arm_req = 1'b1;
        do_tick();
        check("cap2_cleared", int'(cap_done), 0);
        run_frames(3);
        check("cap2_never_done", int'(cap_done), 0);
        check("cap2_data_held", int'(cap_data), 8'h3C);

        // Re-arm while still armed: new coordinates take over.
        mode = 1; cap_x = 10'd3; cap_y = 10'd1; arm_req = 1'b1;
        do_tick();
        run_frames(1);
        check("cap3_done", int'(cap_done), 1);
        check("cap3_data", int'(cap_data), 8'h13);

        // Asynchronous reset mid-line.
        while (hc != 7)
            do_tick();
        #2 reset = 1'b0;
        #1;
        check("rst_async_outputs", int'(|{locked, pix_valid, x, y, pix_data, frame_start,
                                          cap_data, cap_done, err}), 0);
        check("rst_async_err_cnt", int'(err_cnt), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        mode = 3;
        run_frames(1);
        check("rst_partial_locked", int'(locked), 0);
        run_frames(2);
        check("rst_train_locked", int'(locked), 0);
        run_frames(1);
        check("rst_relock", int'(locked), 1);
        check("rst_pix_count", pv_cnt, 32);
        check("rst_bad_pixels", bad_cnt, 0);
`ifdef VGA_RX_CHECKSUM_EN
        check("sum_not_loaded", int'(frame_sum), 0);
        run_frames(1);
        check("sum_locked_frame", int'(frame_sum), 32);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
